// File: rtl/stage_rr_arbiter_if.sv
// Handshake bundle between N_REQ producers, the round-robin arbiter and the shared stage.
// The arbiter uses the slave view; whatever drives producers and the shared stage uses master.
interface stage_rr_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 5,
   parameter int ID_W  = 2
);
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_num;
   logic                   out_valid;
   logic                   out_ready;
   logic [WIDTH-1:0]       out_num;
   logic [ID_W-1:0]        out_id;

   modport slave (
      input  req_valid,
      input  req_num,
      input  out_ready,
      output req_ready,
      output out_valid,
      output out_num,
      output out_id
   );

   modport master (
      output req_valid,
      output req_num,
      output out_ready,
      input  req_ready,
      input  out_valid,
      input  out_num,
      input  out_id
   );
endinterface

// File: rtl/stage_rr_arbiter.sv
// Round-robin arbiter sharing one downstream pipeline stage among N_REQ producers.
// The winning number and its source index sit in a single-entry registered output buffer.
module stage_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 5,
   parameter int ID_W  = 2
) (
   input  logic              clk,
   input  logic              reset,
   stage_rr_arbiter_if.slave bus
);
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    ptr_next;
   logic [ID_W-1:0]    grant_idx;
   logic [ID_W:0]      sum_idx;
   logic               grant_found;
   logic               load_en;
   logic               transfer;
   logic [2*N_REQ-1:0] valid_rot;
   logic [N_REQ-1:0]   ready_vec;
   logic [WIDTH-1:0]   grant_num;
   logic               out_valid_q;
   logic [WIDTH-1:0]   out_num_q;
   logic [ID_W-1:0]    out_id_q;

   assign load_en = !out_valid_q || bus.out_ready;

   // Rotating the doubled valid vector by ptr makes bit k mean requester (ptr+k) mod N_REQ.
   always_comb begin
      valid_rot   = {bus.req_valid, bus.req_valid} >> ptr;
      grant_found = 1'b0;
      grant_idx   = '0;
      sum_idx     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!grant_found && valid_rot[k]) begin
            grant_found = 1'b1;
            sum_idx     = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum_idx >= (ID_W+1)'(N_REQ)) begin
               sum_idx = sum_idx - (ID_W+1)'(N_REQ);
            end
            grant_idx = sum_idx[ID_W-1:0];
         end
      end
   end

   always_comb begin
      ready_vec = '0;
      if (!reset && load_en && grant_found) begin
         ready_vec[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      grant_num = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant_idx == ID_W'(k)) begin
            grant_num = bus.req_num[k*WIDTH +: WIDTH];
         end
      end
   end

   assign transfer = |(bus.req_valid & ready_vec);
   assign ptr_next = (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_num_q   <= '0;
         out_id_q    <= '0;
         ptr         <= '0;
      end else if (transfer) begin
         out_valid_q <= 1'b1;
         out_num_q   <= grant_num;
         out_id_q    <= grant_idx;
         ptr         <= ptr_next;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.req_ready = ready_vec;
   assign bus.out_valid = out_valid_q;
   assign bus.out_num   = out_num_q;
   assign bus.out_id    = out_id_q;
endmodule

// File: tb/tb_stage_rr_arbiter.sv
// Self-checking bench for stage_rr_arbiter: directed vectors with literal expectations
// plus a distance-based round-robin reference model compared on every falling edge.
module tb_stage_rr_arbiter;
   localparam int N  = 4;
   localparam int W  = 5;
   localparam int IW = 2;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   stage_rr_arbiter_if #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) bus_if ();

   stage_rr_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Reference model: grant is the valid requester at the smallest forward distance from ptr.
   logic          m_valid = 1'b0;
   logic [W-1:0]  m_num   = '0;
   logic [IW-1:0] m_id    = '0;
   int            m_ptr   = 0;

   always @(negedge clk) begin
      int best;
      int bestd;
      int d;
      logic load;
      logic [N-1:0] exp_ready;
      load  = !m_valid || bus_if.out_ready;
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
         if (bus_if.req_valid[i]) begin
            d = (i - m_ptr + N) % N;
            if (d < bestd) begin
               bestd = d;
               best  = i;
            end
         end
      end
      exp_ready = '0;
      if (!reset && load && best >= 0) exp_ready[best] = 1'b1;
      chk("model_req_ready", bus_if.req_ready, exp_ready);
      chk("model_out_valid", bus_if.out_valid, m_valid);
      if (m_valid) begin
         chk("model_out_num", bus_if.out_num, m_num);
         chk("model_out_id", bus_if.out_id, m_id);
      end
      if (reset) begin
         m_valid = 1'b0;
         m_num   = '0;
         m_id    = '0;
         m_ptr   = 0;
      end else if (exp_ready != '0) begin
         m_valid = 1'b1;
         m_num   = bus_if.req_num[best*W +: W];
         m_id    = IW'(best);
         m_ptr   = (best + 1) % N;
      end else if (m_valid && bus_if.out_ready) begin
         m_valid = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset            = 1'b1;
      bus_if.req_valid = 4'b1111;
      bus_if.req_num   = {5'd4, 5'd3, 5'd2, 5'd1};
      bus_if.out_ready = 1'b1;

      repeat (2) begin
         cyc();
         chk("rst_req_ready", bus_if.req_ready, 4'b0000);
         chk("rst_out_valid", bus_if.out_valid, 1'b0);
         chk("rst_out_id", bus_if.out_id, 2'd0);
      end
      reset = 1'b0;
      #1 chk("first_grant_ready", bus_if.req_ready, 4'b0001);
      bus_if.req_valid = 4'b0000;
      #1 chk("idle_ready", bus_if.req_ready, 4'b0000);
      cyc();

      // Single requester 2
      bus_if.req_valid = 4'b0100;
      bus_if.req_num   = {5'd0, 5'd7, 5'd0, 5'd0};
      #1 chk("single_ready", bus_if.req_ready, 4'b0100);
      chk("single_pre_valid", bus_if.out_valid, 1'b0);
      cyc();
      bus_if.req_valid = 4'b0000;
      #1 chk("single_out_valid", bus_if.out_valid, 1'b1);
      chk("single_out_num", bus_if.out_num, 5'd7);
      chk("single_out_id", bus_if.out_id, 2'd2);
      chk("single_ready_after", bus_if.req_ready, 4'b0000);
      cyc();
      chk("single_drain", bus_if.out_valid, 1'b0);

      reset = 1'b1;
      cyc();
      reset = 1'b0;

      // Full contention
      bus_if.req_valid = 4'b1111;
      bus_if.req_num   = {5'd4, 5'd3, 5'd2, 5'd1};
      #1 chk("cont_first_ready", bus_if.req_ready, 4'b0001);
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk("cont_out_valid", bus_if.out_valid, 1'b1);
         chk("cont_out_id", bus_if.out_id, 32'(k % 4));
         chk("cont_out_num", bus_if.out_num, 32'(k % 4 + 1));
      end
      cyc();
      chk("bp_pre_id", bus_if.out_id, 2'd2);
      chk("bp_pre_num", bus_if.out_num, 5'd3);

      // Backpressure
      bus_if.out_ready = 1'b0;
      #1 chk("bp_ready", bus_if.req_ready, 4'b0000);
      repeat (3) begin
         cyc();
         chk("bp_out_valid", bus_if.out_valid, 1'b1);
         chk("bp_out_num", bus_if.out_num, 5'd3);
         chk("bp_out_id", bus_if.out_id, 2'd2);
         chk("bp_hold_ready", bus_if.req_ready, 4'b0000);
      end
      bus_if.out_ready = 1'b1;
      #1 chk("bp_release_ready", bus_if.req_ready, 4'b1000);
      cyc();
      chk("bp_release_id", bus_if.out_id, 2'd3);
      chk("bp_release_num", bus_if.out_num, 5'd4);

      // Wrap and skip with requesters 1 and 3
      bus_if.req_valid = 4'b1010;
      #1 chk("wrap_ready0", bus_if.req_ready, 4'b0010);
      cyc();
      chk("wrap_id0", bus_if.out_id, 2'd1);
      chk("wrap_num0", bus_if.out_num, 5'd2);
      chk("wrap_ready1", bus_if.req_ready, 4'b1000);
      cyc();
      chk("wrap_id1", bus_if.out_id, 2'd3);
      chk("wrap_num1", bus_if.out_num, 5'd4);
      chk("wrap_ready2", bus_if.req_ready, 4'b0010);
      cyc();
      chk("wrap_id2", bus_if.out_id, 2'd1);

      // Reset while an item is held under backpressure
      bus_if.req_valid = 4'b0000;
      bus_if.out_ready = 1'b0;
      cyc();
      chk("midrst_held_valid", bus_if.out_valid, 1'b1);
      reset = 1'b1;
      cyc();
      chk("midrst_out_valid", bus_if.out_valid, 1'b0);
      chk("midrst_ready", bus_if.req_ready, 4'b0000);
      reset            = 1'b0;
      bus_if.req_valid = 4'b1111;
      bus_if.out_ready = 1'b1;
      #1 chk("midrst_grant_ready", bus_if.req_ready, 4'b0001);
      cyc();
      chk("midrst_out_id", bus_if.out_id, 2'd0);
      chk("midrst_out_num", bus_if.out_num, 5'd1);
      bus_if.req_valid = 4'b0000;
      repeat (2) cyc();

      // Mixed traffic checked by the model only
      for (int n = 0; n < 300; n++) begin
         bus_if.req_valid = 4'($urandom_range(0, 15));
         bus_if.req_num   = 20'($urandom);
         bus_if.out_ready = ($urandom_range(0, 3) != 0);
         reset            = ($urandom_range(0, 49) == 0);
         cyc();
      end
      reset            = 1'b0;
      bus_if.req_valid = 4'b0000;
      repeat (2) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
